// File: rtl/simon_pkg.sv
// Shared definitions for the Simon button encoder: colour codes and handshake FSM states.
package simon_pkg;

  localparam logic [1:0] CODE_U = 2'd0;
  localparam logic [1:0] CODE_R = 2'd1;
  localparam logic [1:0] CODE_D = 2'd2;
  localparam logic [1:0] CODE_L = 2'd3;

  typedef enum logic [1:0] {
    StArmed   = 2'd0,
    StValid   = 2'd1,
    StAckLow  = 2'd2,
    StRelease = 2'd3
  } enc_state_e;

  // Press vector is ordered {U,R,D,L}; a one-hot vector is assumed by the caller.
  function automatic logic [1:0] press_to_code(input logic [3:0] press);
    logic [1:0] c;
    c = CODE_U;
    if (press[2]) c = CODE_R;
    if (press[1]) c = CODE_D;
    if (press[0]) c = CODE_L;
    return c;
  endfunction

endpackage

// File: rtl/simon_button_encoder_debounce.sv
// One push-button: 2-FF synchronizer, hold-time debounce counter and stable level.
// DEB_BYPASS_EN replaces the counter with a direct pass-through of the synchronized level.
module btn_debounce #(
  parameter int unsigned DEB_LIMIT = 500000,
  parameter int unsigned DEB_CNT_W = 20
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic btn,
  output logic stable
);

  logic sync1_q, sync_q;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync_q  <= sync1_q;
    end
  end

`ifdef DEB_BYPASS_EN
  assign stable = sync_q;
`else
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_CNT_W'(DEB_LIMIT - 1)) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`endif

endmodule

// File: rtl/simon_button_encoder.sv
// Debounces the four Simon buttons and hands one colour code per press to the slow game FSM
// over a 4-phase valid/ack handshake. Optional macro: DEB_BYPASS_EN (skip debounce counters).
module simon_button_encoder
  import simon_pkg::*;
#(
  parameter int unsigned DEB_LIMIT = 500000,
  parameter int unsigned DEB_CNT_W = 20
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       Btn_U,
  input  logic       Btn_R,
  input  logic       Btn_D,
  input  logic       Btn_L,
  input  logic       input_en,
  input  logic       code_ack,
  output logic [1:0] code,
  output logic       code_valid,
  output logic       multi_err,
  output logic [3:0] btn_held
);

  logic [3:0] raw, stable, btn_held_q, press;
  logic       en_1_q, en_s_q, ack_1_q, ack_s_q;
  logic       single, multi;
  logic [1:0] code_q;
  logic       multi_err_q;
  enc_state_e state_q, state_d;

  assign raw = {Btn_U, Btn_R, Btn_D, Btn_L};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    btn_debounce #(
      .DEB_LIMIT(DEB_LIMIT),
      .DEB_CNT_W(DEB_CNT_W)
    ) u_deb (
      .board_clk(board_clk),
      .Reset    (Reset),
      .btn      (raw[i]),
      .stable   (stable[i])
    );
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      en_1_q     <= 1'b0;
      en_s_q     <= 1'b0;
      ack_1_q    <= 1'b0;
      ack_s_q    <= 1'b0;
      btn_held_q <= '0;
    end else begin
      en_1_q     <= input_en;
      en_s_q     <= en_1_q;
      ack_1_q    <= code_ack;
      ack_s_q    <= ack_1_q;
      btn_held_q <= stable;
    end
  end

  // btn_held_q doubles as the one-cycle-delayed stable level for edge detection.
  assign press  = stable & ~btn_held_q;
  assign single = $onehot(press);
  assign multi  = (press != '0) && !single;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StArmed;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArmed: begin
        if (en_s_q && single) begin
          state_d = StValid;
        end else if (en_s_q && multi) begin
          state_d = StRelease;
        end
      end
      StValid:   if (ack_s_q) state_d = StAckLow;
      StAckLow:  if (!ack_s_q) state_d = StRelease;
      StRelease: if (stable == '0) state_d = StArmed;
      default:   state_d = StArmed;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      code_q      <= CODE_U;
      multi_err_q <= 1'b0;
    end else begin
      multi_err_q <= (state_q == StArmed) && en_s_q && multi;
      if ((state_q == StArmed) && en_s_q && single) begin
        code_q <= press_to_code(press);
      end
    end
  end

  always_comb begin
    code_valid = (state_q == StValid);
    code       = code_q;
    multi_err  = multi_err_q;
    btn_held   = btn_held_q;
  end

endmodule
